// File: rtl/aes_entropy_responder.sv
// rtl/aes_entropy_responder.sv - entropy endpoint: buffers 128-bit genbits blocks
// and serves them as 32-bit words on a req/ack handshake, LSB word first.
module aes_entropy_responder #(
  parameter int unsigned EntropyWidth = 32,
  parameter int unsigned GenBitsWidth = 128,
  parameter int unsigned Depth        = 2,
  localparam int unsigned Words       = GenBitsWidth / EntropyWidth,
  localparam int unsigned LvlW        = $clog2(Depth * Words + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    enable_i,
  input  logic                    clr_i,
  input  logic                    gen_valid_i,
  output logic                    gen_ready_o,
  input  logic [GenBitsWidth-1:0] gen_bits_i,
  input  logic                    gen_fips_i,
  input  logic                    entropy_req_i,
  output logic                    entropy_ack_o,
  output logic [EntropyWidth-1:0] entropy_o,
  output logic                    entropy_fips_o,
  output logic [LvlW-1:0]         level_o,
  output logic [15:0]             underrun_cnt_o
);

  localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW  = $clog2(Depth + 1);
  localparam int unsigned WselW = (Words > 1) ? $clog2(Words) : 1;

  logic [GenBitsWidth-1:0] mem_bits_q [Depth];
  logic [Depth-1:0]        mem_fips_q;

  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WselW-1:0] wsel_q, wsel_d;
  logic [15:0]      urun_q, urun_d;

  logic full, empty, push, ack, pop, starve, last_word;

  logic [GenBitsWidth-1:0]                head_bits;
  logic [Words-1:0][EntropyWidth-1:0]     head_words;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Flush outranks everything: no push, ack or underrun in a clr_i cycle.
  always_comb begin
    full        = (cnt_q == CntW'(Depth));
    empty       = (cnt_q == '0);
    gen_ready_o = enable_i && !full && !clr_i;
    push        = gen_valid_i && gen_ready_o;
    ack         = entropy_req_i && enable_i && !empty && !clr_i;
    last_word   = (wsel_q == WselW'(Words - 1));
    pop         = ack && last_word;
    starve      = entropy_req_i && enable_i && empty && !clr_i;
  end

  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    wsel_d = wsel_q;
    urun_d = urun_q;
    if (clr_i) begin
      rptr_d = '0;
      wptr_d = '0;
      cnt_d  = '0;
      wsel_d = '0;
      urun_d = '0;
    end else begin
      if (push) begin
        wptr_d = ptr_inc(wptr_q);
      end
      if (ack) begin
        wsel_d = last_word ? '0 : wsel_q + WselW'(1);
      end
      if (pop) begin
        rptr_d = ptr_inc(rptr_q);
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CntW'(1);
        2'b01:   cnt_d = cnt_q - CntW'(1);
        default: cnt_d = cnt_q;
      endcase
      if (starve && (urun_q != 16'hFFFF)) begin
        urun_d = urun_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      wsel_q <= '0;
      urun_q <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
      wsel_q <= wsel_d;
      urun_q <= urun_d;
    end
  end

  // Payload storage needs no reset: it is only observable behind ack.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_bits_q[wptr_q] <= gen_bits_i;
      mem_fips_q[wptr_q] <= gen_fips_i;
    end
  end

  assign head_bits      = mem_bits_q[rptr_q];
  assign head_words     = head_bits;
  assign entropy_ack_o  = ack;
  assign entropy_o      = ack ? head_words[wsel_q] : '0;
  assign entropy_fips_o = ack ? mem_fips_q[rptr_q] : 1'b0;
  assign level_o        = LvlW'(cnt_q) * LvlW'(Words) - LvlW'(wsel_q);
  assign underrun_cnt_o = urun_q;

endmodule

// File: tb/tb_aes_entropy_responder.sv
// tb/tb_aes_entropy_responder.sv - self-checking bench: word-queue reference
// model compared every cycle, directed scenarios plus randomized traffic.
module tb_aes_entropy_responder;

  localparam int DEPTH = 2;
  localparam int WORDS = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          enable_i;
  logic          clr_i;
  logic          gen_valid_i;
  logic          gen_ready_o;
  logic [127:0]  gen_bits_i;
  logic          gen_fips_i;
  logic          entropy_req_i;
  logic          entropy_ack_o;
  logic [31:0]   entropy_o;
  logic          entropy_fips_o;
  logic [3:0]    level_o;
  logic [15:0]   underrun_cnt_o;

  int checks = 0;
  int errors = 0;

  logic [32:0] mq[$];
  int          m_urun;

  localparam logic [127:0] B0 = 128'h00000004_00000003_00000002_00000001;
  localparam logic [127:0] B1 = 128'h00000008_00000007_00000006_00000005;
  localparam logic [127:0] B2 = 128'h0000000c_0000000b_0000000a_00000009;
  localparam logic [127:0] B3 = 128'h00000010_0000000f_0000000e_0000000d;

  aes_entropy_responder dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .enable_i       (enable_i),
    .clr_i          (clr_i),
    .gen_valid_i    (gen_valid_i),
    .gen_ready_o    (gen_ready_o),
    .gen_bits_i     (gen_bits_i),
    .gen_fips_i     (gen_fips_i),
    .entropy_req_i  (entropy_req_i),
    .entropy_ack_o  (entropy_ack_o),
    .entropy_o      (entropy_o),
    .entropy_fips_o (entropy_fips_o),
    .level_o        (level_o),
    .underrun_cnt_o (underrun_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs, compare DUT against the word queue, then advance the model.
  task automatic step(input logic en, input logic clr, input logic gv,
                      input logic [127:0] bits, input logic fips, input logic req);
    int  nblk;
    logic e_full, e_empty, e_ready, e_ack;
    logic [31:0] e_word;
    logic e_fips;
    @(negedge clk_i);
    enable_i      = en;
    clr_i         = clr;
    gen_valid_i   = gv;
    gen_bits_i    = bits;
    gen_fips_i    = fips;
    entropy_req_i = req;
    #1;
    nblk    = (mq.size() + WORDS - 1) / WORDS;
    e_full  = (nblk == DEPTH);
    e_empty = (mq.size() == 0);
    e_ready = en && !e_full && !clr;
    e_ack   = req && en && !e_empty && !clr;
    e_word  = e_ack ? mq[0][31:0] : 32'h0;
    e_fips  = e_ack ? mq[0][32] : 1'b0;
    chk("m_ready", 128'(gen_ready_o), 128'(e_ready));
    chk("m_ack", 128'(entropy_ack_o), 128'(e_ack));
    chk("m_word", 128'(entropy_o), 128'(e_word));
    chk("m_fips", 128'(entropy_fips_o), 128'(e_fips));
    chk("m_level", 128'(level_o), 128'(mq.size()));
    chk("m_urun", 128'(underrun_cnt_o), 128'(m_urun));
    if (clr) begin
      mq.delete();
      m_urun = 0;
    end else begin
      if (e_ack) void'(mq.pop_front());
      if (req && en && e_empty && m_urun < 16'hFFFF) m_urun++;
      if (gv && e_ready) begin
        for (int w = 0; w < WORDS; w++) mq.push_back({fips, bits[w*32 +: 32]});
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni        = 1'b0;
    enable_i      = 1'($urandom);
    entropy_req_i = 1'b1;
    gen_valid_i   = 1'b1;
    gen_bits_i    = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk_i);
    rst_ni        = 1'b1;
    enable_i      = 1'b0;
    clr_i         = 1'b0;
    entropy_req_i = 1'b0;
    gen_valid_i   = 1'b0;
    mq.delete();
    m_urun = 0;
  endtask

  initial begin
    rst_ni = 1'b0; enable_i = 1'b0; clr_i = 1'b0; gen_valid_i = 1'b0;
    gen_bits_i = '0; gen_fips_i = 1'b0; entropy_req_i = 1'b0;
    mq.delete(); m_urun = 0;
    repeat (2) @(posedge clk_i);

    // Reset state
    do_reset();
    step(1, 0, 0, '0, 0, 0);
    chk("rst_ready", 128'(gen_ready_o), 128'(1));
    chk("rst_level", 128'(level_o), 128'(0));
    chk("rst_urun", 128'(underrun_cnt_o), 128'(0));
    step(1, 0, 0, '0, 0, 1);
    chk("rst_ack", 128'(entropy_ack_o), 128'(0));
    chk("rst_word", 128'(entropy_o), 128'(0));

    // Single block, LSB word first, level counting down
    do_reset();
    step(1, 0, 1, B0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, '0, 0, 1);
      chk("b0_ack", 128'(entropy_ack_o), 128'(1));
      chk("b0_word", 128'(entropy_o), 128'(i + 1));
      chk("b0_fips", 128'(entropy_fips_o), 128'(1));
      chk("b0_level", 128'(level_o), 128'(4 - i));
    end
    step(1, 0, 0, '0, 0, 0);
    chk("b0_level_end", 128'(level_o), 128'(0));

    // Starvation then push: count 5, ack the cycle after push
    do_reset();
    repeat (5) step(1, 0, 0, '0, 0, 1);
    step(1, 0, 1, B0, 0, 0);
    chk("urun5", 128'(underrun_cnt_o), 128'(5));
    step(1, 0, 0, '0, 0, 1);
    chk("urun_first_ack", 128'(entropy_ack_o), 128'(1));
    chk("urun_first_word", 128'(entropy_o), 128'(1));
    repeat (3) step(1, 0, 0, '0, 0, 1);

    // Full FIFO, pop does not reopen ready in the same cycle
    do_reset();
    step(1, 0, 1, B1, 0, 0);
    step(1, 0, 1, B2, 0, 0);
    step(1, 0, 1, B3, 0, 0);
    chk("full_ready", 128'(gen_ready_o), 128'(0));
    chk("full_level", 128'(level_o), 128'(8));
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1, B3, 0, 1);
      chk("full_pop_ready", 128'(gen_ready_o), 128'(0));
      chk("full_pop_word", 128'(entropy_o), 128'(5 + i));
    end
    step(1, 0, 1, B3, 0, 0);
    chk("reopen_ready", 128'(gen_ready_o), 128'(1));
    chk("reopen_level", 128'(level_o), 128'(4));
    step(1, 0, 0, '0, 0, 0);
    chk("reopen_level8", 128'(level_o), 128'(8));

    // Request drop mid-block resumes at the next unserved word
    step(1, 0, 0, '0, 0, 1);
    chk("drop_w1", 128'(entropy_o), 128'(9));
    step(1, 0, 0, '0, 0, 1);
    chk("drop_w2", 128'(entropy_o), 128'(10));
    repeat (3) begin
      step(1, 0, 0, '0, 0, 0);
      chk("drop_noack", 128'(entropy_ack_o), 128'(0));
    end
    step(1, 0, 0, '0, 0, 1);
    chk("drop_w3", 128'(entropy_o), 128'(11));
    step(1, 0, 0, '0, 0, 1);
    chk("drop_w4", 128'(entropy_o), 128'(12));
    step(1, 0, 0, '0, 0, 1);
    chk("drop_next", 128'(entropy_o), 128'(13));

    // Flush with level 6 and pending req/valid
    do_reset();
    repeat (3) step(1, 0, 0, '0, 0, 1);
    step(1, 0, 1, B0, 0, 0);
    step(1, 0, 1, B1, 0, 0);
    repeat (2) step(1, 0, 0, '0, 0, 1);
    step(1, 1, 1, B2, 1, 1);
    chk("clr_ack", 128'(entropy_ack_o), 128'(0));
    chk("clr_ready", 128'(gen_ready_o), 128'(0));
    chk("clr_level_before", 128'(level_o), 128'(6));
    chk("clr_urun_before", 128'(underrun_cnt_o), 128'(3));
    step(1, 0, 0, '0, 0, 0);
    chk("clr_level", 128'(level_o), 128'(0));
    chk("clr_urun", 128'(underrun_cnt_o), 128'(0));

    // Reset mid-block discards the partial block
    step(1, 0, 1, B0, 0, 0);
    step(1, 0, 0, '0, 0, 1);
    do_reset();
    step(1, 0, 0, '0, 0, 0);
    chk("midrst_level", 128'(level_o), 128'(0));
    step(1, 0, 1, B1, 0, 0);
    step(1, 0, 0, '0, 0, 1);
    chk("midrst_word", 128'(entropy_o), 128'(5));

    // Disable holds state; then saturate the underrun counter
    do_reset();
    step(1, 0, 1, B0, 0, 0);
    step(1, 0, 0, '0, 0, 1);
    repeat (3) begin
      step(0, 0, 1, B1, 0, 1);
      chk("dis_ack", 128'(entropy_ack_o), 128'(0));
      chk("dis_ready", 128'(gen_ready_o), 128'(0));
      chk("dis_urun", 128'(underrun_cnt_o), 128'(0));
    end
    step(1, 0, 0, '0, 0, 1);
    chk("dis_resume", 128'(entropy_o), 128'(2));
    repeat (2) step(1, 0, 0, '0, 0, 1);
    repeat (70000) step(1, 0, 0, '0, 0, 1);
    chk("urun_sat", 128'(underrun_cnt_o), 128'(16'hFFFF));
    step(0, 0, 0, '0, 0, 1);
    chk("urun_sat_dis", 128'(underrun_cnt_o), 128'(16'hFFFF));

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 9) != 0),
             ($urandom_range(0, 29) == 0),
             1'($urandom),
             {$urandom, $urandom, $urandom, $urandom},
             1'($urandom),
             ($urandom_range(0, 9) < 6));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
